// File: rtl/display_scan_controller.sv
// Row/bit-plane scan sequencer for a HUB75-style LED panel: reads one row pair,
// shifts the selected bit plane out with display_clk, latches, then runs the BCM on-time.
//
// state   | meaning
// --------+-------------------------------------------------------------
// idle    | outputs quiet, waiting for enable
// shift   | read columns, capture encoded pixels, pulse display_clk
// latch   | one-cycle panel latch, row_addr updated
// display | oe_n low for base_cycles<<plane cycles, counters advance
module display_scan_controller #(
  parameter int columns     = 64,
  parameter int rows        = 32,
  parameter int segments    = 2,
  parameter int bits        = 8,
  parameter int base_cycles = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            enable,
  output logic                                            fb_rd,
  output logic [((rows/segments > 1) ? $clog2(rows/segments) : 1)+$clog2(columns)-1:0] fb_addr,
  input  logic [segments*24-1:0]                          cpixel,
  output logic [segments*3-1:0]                           rgb,
  output logic                                            display_clk,
  output logic                                            latch,
  output logic                                            oe_n,
  output logic [((rows/segments > 1) ? $clog2(rows/segments) : 1)-1:0] row_addr,
  output logic                                            frame_done
);

  localparam int row_w = (rows/segments > 1) ? $clog2(rows/segments) : 1;
  localparam int col_w = $clog2(columns);
  localparam int cyc_w = $clog2(2*columns+3);
  localparam int tmr_w = $clog2(base_cycles << (bits-1)) + 1;
  localparam int pln_w = (bits > 1) ? $clog2(bits) : 1;

  localparam logic [cyc_w-1:0] shift_last = cyc_w'(2*columns+2);
  localparam logic [cyc_w-1:0] read_end   = cyc_w'(2*columns);
  localparam logic [cyc_w-1:0] clk_first  = cyc_w'(4);
  localparam logic [cyc_w-1:0] cap_first  = cyc_w'(2);
  localparam logic [row_w-1:0] row_last   = row_w'(rows/segments-1);
  localparam logic [pln_w-1:0] plane_last = pln_w'(bits-1);

  typedef enum logic [1:0] {st_idle, st_shift, st_latch, st_display} state_t;

  state_t             state, state_nxt;
  logic [cyc_w-1:0]   cyc;
  logic [tmr_w-1:0]   tmr;
  logic [row_w-1:0]   row, row_q;
  logic [pln_w-1:0]   plane;
  logic [7:0]         plane_mask;
  logic [segments*3-1:0] rgb_next;
  logic               capture;
  logic               tmr_done;

  always_comb begin
    plane_mask = 8'b1 << (4'(8-bits) + 4'(plane));
    rgb_next   = '0;
    for (int s = 0; s < segments; s++) begin
      rgb_next[3*s+2] = |(cpixel[24*s+16 +: 8] & plane_mask);
      rgb_next[3*s+1] = |(cpixel[24*s+8  +: 8] & plane_mask);
      rgb_next[3*s]   = |(cpixel[24*s    +: 8] & plane_mask);
    end
  end

  // encoded pixel for column k arrives two cycles after its read, i.e. at even cycles 2..2*columns
  assign capture  = (state == st_shift) && !cyc[0] && (cyc >= cap_first) && (cyc <= read_end);
  assign tmr_done = (tmr == '0);

  always_comb begin
    state_nxt   = state;
    fb_rd       = 1'b0;
    fb_addr     = '0;
    display_clk = 1'b0;
    latch       = 1'b0;
    oe_n        = 1'b1;
    row_addr    = row_q;
    frame_done  = 1'b0;
    case (state)
      st_idle: begin
        if (enable) state_nxt = st_shift;
      end
      st_shift: begin
        fb_rd       = !cyc[0] && (cyc < read_end);
        if (fb_rd) fb_addr = {row, cyc[col_w:1]};
        display_clk = !cyc[0] && (cyc >= clk_first);
        if (cyc == shift_last) state_nxt = st_latch;
      end
      st_latch: begin
        latch     = 1'b1;
        row_addr  = row;
        state_nxt = st_display;
      end
      st_display: begin
        oe_n = 1'b0;
        if (tmr_done) begin
          frame_done = (plane == plane_last) && (row == row_last);
          state_nxt  = enable ? st_shift : st_idle;
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= st_idle;
      cyc   <= '0;
      tmr   <= '0;
      row   <= '0;
      row_q <= '0;
      plane <= '0;
      rgb   <= '0;
    end else begin
      state <= state_nxt;
      cyc   <= (state == st_shift) ? cyc + 1'b1 : '0;
      if (capture) rgb <= rgb_next;
      if (state == st_latch) begin
        tmr   <= (tmr_w'(base_cycles) << plane) - tmr_w'(1);
        row_q <= row;
      end
      if (state == st_display) begin
        if (!tmr_done) begin
          tmr <= tmr - 1'b1;
        end else if (!enable) begin
          row   <= '0;
          plane <= '0;
          row_q <= '0;
        end else if (plane == plane_last) begin
          plane <= '0;
          row   <= (row == row_last) ? '0 : row + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with columns=4, rows=4, segments=2,
// bits=2, base_cycles=2; cpixel comes from a two-cycle framebuffer+encoder model.
module tb_display_scan_controller;

  localparam int columns = 4, rows = 4, segments = 2, bits = 2, base_cycles = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fb_rd;
  logic [2:0]  fb_addr;
  logic [47:0] cpixel = '0;
  logic [5:0]  rgb;
  logic        display_clk;
  logic        latch;
  logic        oe_n;
  logic [0:0]  row_addr;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [47:0] mem [8];
  logic [47:0] pipe_v = '0;

  localparam logic [23:0] tbl_r0p0 = {6'b100010, 6'b010000, 6'b000111, 6'b111000};
  localparam logic [23:0] tbl_r0p1 = {6'b100010, 6'b000001, 6'b000000, 6'b100000};
  localparam logic [23:0] tbl_r1   = {6'b000000, 6'b000000, 6'b000000, 6'b001010};
  localparam logic [23:0] tbl_post = {6'b100010, 6'b010000, 6'b000111, 6'b000000};
  localparam logic [14:0] reset_vec = {1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  display_scan_controller #(
    .columns(columns), .rows(rows), .segments(segments),
    .bits(bits), .base_cycles(base_cycles)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .cpixel(cpixel), .rgb(rgb), .display_clk(display_clk), .latch(latch),
    .oe_n(oe_n), .row_addr(row_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe_v <= fb_rd ? mem[fb_addr] : '0;
    cpixel <= pipe_v;
  end

  // One full plane period, every cycle checked against hand-derived timing.
  task automatic scan_plane(input logic r, input int p, input int prow,
                            input logic [23:0] tbl, input int drop_c);
    int period = 12 + (2 << p);
    logic exp_rd, exp_dclk, exp_latch, exp_oe, exp_fd;
    logic [0:0] exp_row;
    for (int c = 0; c < period; c++) begin
      @(negedge clk);
      exp_rd    = (c < 8) && (c % 2 == 0);
      exp_dclk  = (c >= 4) && (c <= 10) && (c % 2 == 0);
      exp_latch = (c == 11);
      exp_oe    = (c >= 12) ? 1'b0 : 1'b1;
      exp_fd    = (c == period-1) && (r == 1'b1) && (p == 1);
      exp_row   = (c >= 11) ? r : 1'(prow);
      vectors++;
      if (fb_rd !== exp_rd) begin
        miscompares++;
        $display("FAIL fb_rd r%0d p%0d c%0d got %b want %b", r, p, c, fb_rd, exp_rd);
      end
      if (exp_rd) begin
        vectors++;
        if (fb_addr !== {r, 2'(c/2)}) begin
          miscompares++;
          $display("FAIL fb_addr r%0d p%0d c%0d got %0d want %0d", r, p, c, fb_addr, {r, 2'(c/2)});
        end
      end
      vectors++;
      if (display_clk !== exp_dclk) begin
        miscompares++;
        $display("FAIL display_clk r%0d p%0d c%0d got %b want %b", r, p, c, display_clk, exp_dclk);
      end
      vectors++;
      if (latch !== exp_latch) begin
        miscompares++;
        $display("FAIL latch r%0d p%0d c%0d got %b want %b", r, p, c, latch, exp_latch);
      end
      vectors++;
      if (oe_n !== exp_oe) begin
        miscompares++;
        $display("FAIL oe_n r%0d p%0d c%0d got %b want %b", r, p, c, oe_n, exp_oe);
      end
      vectors++;
      if (row_addr !== exp_row) begin
        miscompares++;
        $display("FAIL row_addr r%0d p%0d c%0d got %b want %b", r, p, c, row_addr, exp_row);
      end
      vectors++;
      if (frame_done !== exp_fd) begin
        miscompares++;
        $display("FAIL frame_done r%0d p%0d c%0d got %b want %b", r, p, c, frame_done, exp_fd);
      end
      if (exp_dclk) begin
        vectors++;
        if (rgb !== tbl[((c-4)/2)*6 +: 6]) begin
          miscompares++;
          $display("FAIL rgb r%0d p%0d col%0d got %b want %b", r, p, (c-4)/2, rgb, tbl[((c-4)/2)*6 +: 6]);
        end
      end
      if (c == drop_c) enable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({fb_rd, fb_addr, rgb, display_clk, latch, oe_n, row_addr, frame_done} !== reset_vec) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want %b",
               {fb_rd, fb_addr, rgb, display_clk, latch, oe_n, row_addr, frame_done}, reset_vec);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({fb_rd, oe_n, latch, display_clk} !== 4'b0100) begin
        miscompares++;
        $display("FAIL idle_hold cycle%0d got %b want 0100", i, {fb_rd, oe_n, latch, display_clk});
      end
    end
  endtask

  task automatic test_scan_timing();
    enable = 1'b1;
    scan_plane(1'b0, 0, 0, tbl_r0p0, -1);
    mem[0] = {24'h800000, 24'h000000};
  endtask

  task automatic test_bitplane();
    scan_plane(1'b0, 1, 0, tbl_r0p1, -1);
  endtask

  task automatic test_row_advance();
    scan_plane(1'b1, 0, 0, tbl_r1, -1);
  endtask

  task automatic test_frame_wrap();
    scan_plane(1'b1, 1, 1, tbl_r1, -1);
  endtask

  task automatic test_enable_drop();
    scan_plane(1'b0, 0, 1, tbl_post, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({fb_rd, oe_n, latch, display_clk, row_addr, frame_done} !== 6'b010000) begin
        miscompares++;
        $display("FAIL idle_after_drop cycle%0d got %b want 010000",
                 i, {fb_rd, oe_n, latch, display_clk, row_addr, frame_done});
      end
    end
    enable = 1'b1;
    scan_plane(1'b0, 0, 0, tbl_post, -1);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 13; c++) @(negedge clk);
    vectors++;
    if (oe_n !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_display got oe_n=%b want 0", oe_n);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({fb_rd, fb_addr, rgb, display_clk, latch, oe_n, row_addr, frame_done} !== reset_vec) begin
      miscompares++;
      $display("FAIL async_reset got %b want %b",
               {fb_rd, fb_addr, rgb, display_clk, latch, oe_n, row_addr, frame_done}, reset_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    scan_plane(1'b0, 0, 0, tbl_post, -1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = {24'hffffff, 24'h000000};
    mem[1] = {24'h000000, 24'h404040};
    mem[2] = {24'h004000, 24'h000080};
    mem[3] = {24'hc00000, 24'h00c000};
    mem[4] = {24'h0000ff, 24'h00ff00};
    test_reset();
    test_scan_timing();
    test_bitplane();
    test_row_advance();
    test_frame_wrap();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
